// File: rtl/fifo_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_byte_serializer
// Purpose  : Read-side consumer of the single-clock byte FIFO. Pops one word
//            at a time and shifts it out MSB-first, holding each bit on
//            tx_bit_o for BIT_PERIOD clocks. The stream feeds the backscatter
//            encoder. This block owns the read handshake; the FIFO owns the
//            storage and the empty flag.
// Revision : 1.0 - initial release
//
// Ports:
//   clock_i         system clock, rising edge
//   reset_i         asynchronous active-high reset
//   enable_i        level; permits fetching new words from the FIFO
//   fifo_empty_i    FIFO empty flag
//   fifo_rd_data_i  FIFO read data, valid one cycle after fifo_rd_en_o
//   fifo_rd_en_o    one-cycle FIFO pop request
//   tx_bit_o        current serial bit
//   tx_valid_o      high while tx_bit_o carries a frame bit
//   bit_strobe_o    one-cycle pulse on the first cycle of each bit
//   byte_done_o     one-cycle pulse on the last cycle of each frame
//   busy_o          high in any state other than IDLE
//
// Build option:
//   SERIALIZER_PARITY_EN - when defined, an even-parity bit (XOR of the data
//   bits) is appended after the last data bit, extending the frame by one
//   bit period. byte_done_o then marks the last cycle of the parity bit.
// ============================================================================
module fifo_byte_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_PERIOD = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  tx_bit_o,
  output logic                  tx_valid_o,
  output logic                  bit_strobe_o,
  output logic                  byte_done_o,
  output logic                  busy_o
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
`endif
  localparam int BCNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [BCNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]        per_cnt_q, per_cnt_d;
  logic [FRAME_BITS-1:0]   load_val;

  // The parity bit rides in the LSB of the shift register so it simply
  // emerges after the data bits without any extra state.
`ifdef SERIALIZER_PARITY_EN
  assign load_val = {fifo_rd_data_i, ^fifo_rd_data_i};
`else
  assign load_val = fifo_rd_data_i;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      per_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    per_cnt_d    = per_cnt_q;
    fifo_rd_en_o = 1'b0;
    tx_bit_o     = 1'b0;
    tx_valid_o   = 1'b0;
    bit_strobe_o = 1'b0;
    byte_done_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i && !fifo_empty_i) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        fifo_rd_en_o = 1'b1;
        state_d      = S_LOAD;
      end

      S_LOAD: begin
        shreg_d   = load_val;
        bit_cnt_d = '0;
        per_cnt_d = '0;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        tx_valid_o   = 1'b1;
        tx_bit_o     = shreg_q[FRAME_BITS-1];
        bit_strobe_o = (per_cnt_q == '0);
        if (per_cnt_q == LAST_TICK) begin
          shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
          per_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            // Last cycle of the frame: the only point besides IDLE where
            // the empty flag is consulted, giving back-to-back frames.
            byte_done_o = 1'b1;
            bit_cnt_d   = '0;
            state_d     = (enable_i && !fifo_empty_i) ? S_FETCH : S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end else begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_byte_serializer
// Purpose  : Self-checking bench for fifo_byte_serializer with a small
//            behavioural FIFO read port (data one cycle after the pop).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_byte_serializer;

  localparam int BP = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd_en, tx_bit, tx_valid, bit_strobe, byte_done, busy;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int bad_pops = 0;
  int total = 0;
  int passed = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_byte_serializer dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .enable_i       (enable),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (rd_data),
    .fifo_rd_en_o   (fifo_rd_en),
    .tx_bit_o       (tx_bit),
    .tx_valid_o     (tx_valid),
    .bit_strobe_o   (bit_strobe),
    .byte_done_o    (byte_done),
    .busy_o         (busy)
  );

  always #5 clock = ~clock;

  // FIFO read port model
  always @(posedge clock) begin
    if (fifo_rd_en) begin
      pops <= pops + 1;
      if (fifo_empty) begin
        bad_pops <= bad_pops + 1;
      end else begin
        rd_data <= mem[rd_ptr[7:0]];
        rd_ptr  <= rd_ptr + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  // Called on a falling edge. Waits (bounded) for tx_valid, then records the
  // frame until tx_valid drops; returns on the first negedge with tx_valid=0.
  task automatic capture_frame(input int drop_at, output int lat, output logic [15:0] bits,
                               output int nbits, output int len, output int strobes,
                               output int done_at, output logic stable);
    logic cur;
    lat = 0; bits = '0; nbits = 0; len = 0; strobes = 0; done_at = -1; stable = 1'b1;
    cur = 1'b0;
    while (!tx_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (!tx_valid) begin
      check("frame_start_timeout", 0, 1);
      return;
    end
    while (tx_valid && len < 100) begin
      len++;
      if (bit_strobe || len == 1) begin
        if (bit_strobe) begin
          strobes++;
          bits  = {bits[14:0], tx_bit};
          nbits++;
          if (strobes == drop_at) enable = 1'b0;
        end
        cur = tx_bit;
      end else if (tx_bit != cur) begin
        stable = 1'b0;
      end
      if (byte_done) done_at = len;
      @(negedge clock);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  int lat, nbits, len, strobes, done_at, p0, n_rd, n_val, exp_stream;
  logic [15:0] bits;
  logic stable;

  initial begin
    vecs[0] = '{8'hA5, 8'b1010_0101, 1'b0};
    vecs[1] = '{8'h81, 8'b1000_0001, 1'b0};
    vecs[2] = '{8'h5A, 8'b0101_1010, 1'b0};
    vecs[3] = '{8'h07, 8'b0000_0111, 1'b1};
    vecs[4] = '{8'h03, 8'b0000_0011, 1'b0};
    vecs[5] = '{8'h80, 8'b1000_0000, 1'b1};

    // ---------------- reset state ----------------
    #1 reset = 1'b1;
    #1;
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_strobe_done", int'({bit_strobe, byte_done, tx_bit}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // ---------------- table-driven single frames ----------------
    for (int i = 0; i < 6; i++) begin
`ifdef SERIALIZER_PARITY_EN
      exp_stream = int'({vecs[i].exp_bits, vecs[i].exp_par});
`else
      exp_stream = int'(vecs[i].exp_bits);
`endif
      p0 = pops;
      push(vecs[i].data);
      enable = 1'b1;
      capture_frame(-1, lat, bits, nbits, len, strobes, done_at, stable);
      check($sformatf("v%0d_latency", i), lat, 3);
      check($sformatf("v%0d_bits", i), int'(bits), exp_stream);
      check($sformatf("v%0d_nbits", i), nbits, FB);
      check($sformatf("v%0d_len", i), len, FB * BP);
      check($sformatf("v%0d_strobes", i), strobes, FB);
      check($sformatf("v%0d_done_at", i), done_at, FB * BP);
      check($sformatf("v%0d_stable", i), int'(stable), 1);
      check($sformatf("v%0d_pops", i), pops - p0, 1);
      check($sformatf("v%0d_busy_after", i), int'(busy), 0);
      enable = 1'b0;
      @(negedge clock);
    end

    // ---------------- back-to-back 0xFF, 0x00 ----------------
    p0 = pops;
    push(8'hFF);
    push(8'h00);
    enable = 1'b1;
    capture_frame(-1, lat, bits, nbits, len, strobes, done_at, stable);
    check("b2b_f1_bits", int'(bits[FB-1:0]), (FB == 9) ? 9'b1_1111_1110 : 8'hFF);
    check("b2b_f1_len", len, FB * BP);
    capture_frame(-1, lat, bits, nbits, len, strobes, done_at, stable);
    check("b2b_gap", lat, 2);
    check("b2b_f2_bits", int'(bits[FB-1:0]), 0);
    check("b2b_f2_strobes", strobes, FB);
    check("b2b_f2_done_at", done_at, FB * BP);
    check("b2b_pops", pops - p0, 2);
    check("b2b_busy_after", int'(busy), 0);
    enable = 1'b0;
    @(negedge clock);

    // ---------------- enable dropped at bit 3 of 0x3C ----------------
    p0 = pops;
    push(8'h3C);
    push(8'h11);
    enable = 1'b1;
    capture_frame(4, lat, bits, nbits, len, strobes, done_at, stable);
    check("endrop_bits", int'(bits[FB-1:0]), (FB == 9) ? 9'b0_0111_1000 : 8'h3C);
    check("endrop_len", len, FB * BP);
    check("endrop_done_at", done_at, FB * BP);
    check("endrop_busy_after", int'(busy), 0);
    n_val = 0;
    repeat (10) begin
      @(negedge clock);
      if (tx_valid) n_val++;
    end
    check("endrop_pops", pops - p0, 1);
    check("endrop_no_valid", n_val, 0);
    wr_ptr = rd_ptr;  // discard the queued byte
    @(negedge clock);

    // ---------------- empty guard ----------------
    enable = 1'b1;
    n_rd = 0;
    n_val = 0;
    repeat (50) begin
      @(negedge clock);
      if (fifo_rd_en) n_rd++;
      if (tx_valid) n_val++;
    end
    check("empty_no_rd_en", n_rd, 0);
    check("empty_no_valid", n_val, 0);
    enable = 1'b0;
    @(negedge clock);

    // ---------------- asynchronous reset mid-frame ----------------
    push(8'hA5);
    enable = 1'b1;
    lat = 0;
    while (!tx_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("rstmid_started", int'(tx_valid), 1);
    repeat (8) @(negedge clock);
    check("rstmid_bit_before", int'(tx_bit), 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rstmid_tx_valid", int'(tx_valid), 0);
    check("rstmid_tx_bit", int'(tx_bit), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_strobe_done_rd", int'({bit_strobe, byte_done, fifo_rd_en}), 0);
    @(negedge clock);
    reset = 1'b0;
    n_rd = 0;
    repeat (20) begin
      @(negedge clock);
      if (fifo_rd_en) n_rd++;
    end
    check("rstmid_no_fetch", n_rd, 0);
    check("rstmid_idle", int'(busy), 0);
    enable = 1'b0;

    check("no_pop_when_empty", bad_pops, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
